// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: holds HI/LO, runs mult/multu/div/divu with a
// fixed busy latency, and handles mthi/mtlo while idle. The result is computed
// and latched on the start edge. It is written to HI/LO when the countdown expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1_f,
    input  logic [31:0] E_V2_f,
    input  logic [3:0]  MDUOp,
    input  logic        MDUSel,
    output logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      res_q, res_d;

    // Arithmetic datapath: both products and both quotient/remainder pairs.
    logic [63:0] umul_s, smul_s;
    logic        div_zero_s;
    logic [31:0] udiv_den_s, u_quo_s, u_rem_s;
    logic [31:0] a_mag_s, b_mag_s, q_mag_s, r_mag_s, s_quo_s, s_rem_s;

    // Products and divides; signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
    always_comb begin
        umul_s     = {32'd0, E_V1_f} * {32'd0, E_V2_f};
        smul_s     = {{32{E_V1_f[31]}}, E_V1_f} * {{32{E_V2_f[31]}}, E_V2_f};
        div_zero_s = (E_V2_f == 32'd0);
        udiv_den_s = div_zero_s ? 32'd1 : E_V2_f;
        u_quo_s    = E_V1_f / udiv_den_s;
        u_rem_s    = E_V1_f % udiv_den_s;
        a_mag_s    = E_V1_f[31] ? (~E_V1_f + 32'd1) : E_V1_f;
        b_mag_s    = div_zero_s ? 32'd1 : (E_V2_f[31] ? (~E_V2_f + 32'd1) : E_V2_f);
        q_mag_s    = a_mag_s / b_mag_s;
        r_mag_s    = a_mag_s % b_mag_s;
        s_quo_s    = (E_V1_f[31] ^ E_V2_f[31]) ? (~q_mag_s + 32'd1) : q_mag_s;
        s_rem_s    = E_V1_f[31] ? (~r_mag_s + 32'd1) : r_mag_s;
    end

    // A start is only accepted while idle; ops 1..4 while busy are dropped.
    always_comb begin
        case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: E_MDU_start = ~busy_q;
            default:                            E_MDU_start = 1'b0;
        endcase
    end

    // Next-state: countdown while busy, otherwise decode start / mthi / mtlo.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                hi_d   = res_q[63:32];
                lo_d   = res_q[31:0];
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            case (MDUOp)
                OP_MULT: begin
                    res_d  = smul_s;
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    busy_d = 1'b1;
                end
                OP_MULTU: begin
                    res_d  = umul_s;
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    busy_d = 1'b1;
                end
                OP_DIV: begin
                    // Divide by zero writes back the unchanged HI/LO.
                    res_d  = div_zero_s ? {hi_q, lo_q} : {s_rem_s, s_quo_s};
                    cnt_d  = CNT_W'(DIV_CYCLES);
                    busy_d = 1'b1;
                end
                OP_DIVU: begin
                    res_d  = div_zero_s ? {hi_q, lo_q} : {u_rem_s, u_quo_s};
                    cnt_d  = CNT_W'(DIV_CYCLES);
                    busy_d = 1'b1;
                end
                OP_MTHI: hi_d = E_V1_f;
                OP_MTLO: lo_d = E_V1_f;
                default: begin
                    hi_d = hi_q;
                end
            endcase
        end
    end

    // State registers; reset discards any in-flight operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            res_q  <= 64'd0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
        end
    end

    assign E_MDU_busy = busy_q;
    assign E_HI       = hi_q;
    assign E_LO       = lo_q;
    assign E_MDU_out  = MDUSel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a vector table for single operations plus
// hand-written sequences for busy-time interference, async reset and readout.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_V1_f, E_V2_f;
    logic [3:0]  MDUOp;
    logic        MDUSel;
    logic        E_MDU_start, E_MDU_busy;
    logic [31:0] E_MDU_out, E_HI, E_LO;

    int n_checks = 0;
    int n_fail   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_V1_f(E_V1_f), .E_V2_f(E_V2_f),
        .MDUOp(MDUOp), .MDUSel(MDUSel), .E_MDU_start(E_MDU_start),
        .E_MDU_busy(E_MDU_busy), .E_MDU_out(E_MDU_out), .E_HI(E_HI), .E_LO(E_LO)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles busy stays high (bounded), checking HI/LO hold meanwhile.
    task automatic count_busy(input int start_n, input logic [31:0] hold_hi,
                              input logic [31:0] hold_lo, output int n);
        n = start_n;
        while (E_MDU_busy === 1'b1 && n < 40) begin
            n++;
            chk("hold_hi", E_HI, hold_hi);
            chk("hold_lo", E_LO, hold_lo);
            step();
        end
    endtask

    logic [31:0] cur_hi, cur_lo;
    int n;

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{4'd5, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h00000003};
        vecs[5]  = '{4'd6, 32'hCAFEBABE, 32'h00000000, 0,  32'h12345678, 32'hCAFEBABE};
        vecs[6]  = '{4'd3, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'hCAFEBABE};
        vecs[7]  = '{4'd4, 32'h00000009, 32'h00000000, 10, 32'h12345678, 32'hCAFEBABE};
        vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[9]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
        vecs[11] = '{4'd2, 32'h80000000, 32'h00000002, 5,  32'h00000001, 32'h00000000};
        vecs[12] = '{4'd1, 32'h00000004, 32'h00000005, 5,  32'h00000000, 32'h00000014};

        reset = 1'b1; E_V1_f = 32'd0; E_V2_f = 32'd0; MDUOp = 4'd0; MDUSel = 1'b0;
        #1;
        chk("rst_busy",  E_MDU_busy, 1'b0);
        chk("rst_hi",    E_HI, 32'd0);
        chk("rst_lo",    E_LO, 32'd0);
        chk("rst_start", E_MDU_start, 1'b0);
        chk("rst_out",   E_MDU_out, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // Table-driven single operations.
        for (int i = 0; i < 13; i++) begin
            MDUOp  = vecs[i].op;
            E_V1_f = vecs[i].a;
            E_V2_f = vecs[i].b;
            #1;
            chk($sformatf("v%0d_start", i), E_MDU_start,
                (vecs[i].op >= 4'd1 && vecs[i].op <= 4'd4) ? 1'b1 : 1'b0);
            step();
            MDUOp = 4'd0;
            count_busy(0, cur_hi, cur_lo, n);
            chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
            chk($sformatf("v%0d_hi", i), E_HI, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), E_LO, vecs[i].lo);
            MDUSel = 1'b1; #1;
            chk($sformatf("v%0d_out_hi", i), E_MDU_out, vecs[i].hi);
            MDUSel = 1'b0; #1;
            chk($sformatf("v%0d_out_lo", i), E_MDU_out, vecs[i].lo);
            cur_hi = vecs[i].hi;
            cur_lo = vecs[i].lo;
        end

        // MULT 4x5 with MTLO and DIV presented while busy, then back-to-back MULT.
        MDUOp = 4'd1; E_V1_f = 32'd4; E_V2_f = 32'd5;
        step();
        MDUOp = 4'd0;
        chk("ib_busy1", E_MDU_busy, 1'b1);
        step();
        MDUOp = 4'd6; E_V1_f = 32'd1; #1;
        chk("ib_mtlo_start", E_MDU_start, 1'b0);
        step();
        MDUOp = 4'd3; E_V1_f = 32'd9; E_V2_f = 32'd2; #1;
        chk("ib_div_start", E_MDU_start, 1'b0);
        step();
        MDUOp = 4'd1; E_V1_f = 32'd2; E_V2_f = 32'd3;
        count_busy(3, cur_hi, cur_lo, n);
        chk("ib_cycles", n, 5);
        chk("ib_lo", E_LO, 32'd20);
        chk("ib_hi", E_HI, 32'd0);
        chk("ib_b2b_start", E_MDU_start, 1'b1);
        step();
        MDUOp = 4'd0;
        chk("ib_b2b_busy", E_MDU_busy, 1'b1);
        count_busy(0, 32'd0, 32'd20, n);
        chk("ib_b2b_cycles", n, 5);
        chk("ib_b2b_lo", E_LO, 32'd6);
        chk("ib_b2b_hi", E_HI, 32'd0);

        // Async reset in the middle of busy cycle 4 of a DIV.
        MDUOp = 4'd5; E_V1_f = 32'hA5A5A5A5;
        step();
        chk("mr_mthi", E_HI, 32'hA5A5A5A5);
        MDUOp = 4'd3; E_V1_f = 32'd100; E_V2_f = 32'd7;
        step();
        MDUOp = 4'd0;
        step(); step(); step();
        chk("mr_busy_pre", E_MDU_busy, 1'b1);
        #4;
        reset = 1'b1;
        #1;
        chk("mr_busy", E_MDU_busy, 1'b0);
        chk("mr_hi", E_HI, 32'd0);
        chk("mr_lo", E_LO, 32'd0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("mr_late_busy", E_MDU_busy, 1'b0);
        chk("mr_late_hi", E_HI, 32'd0);
        chk("mr_late_lo", E_LO, 32'd0);

        // Readout select while idle, and an undefined opcode.
        MDUOp = 4'd5; E_V1_f = 32'h11111111;
        step();
        MDUOp = 4'd6; E_V1_f = 32'h22222222;
        step();
        MDUOp = 4'd9; E_V1_f = 32'h33333333; E_V2_f = 32'h44444444;
        MDUSel = 1'b1; #1;
        chk("sel_hi", E_MDU_out, 32'h11111111);
        MDUSel = 1'b0; #1;
        chk("sel_lo", E_MDU_out, 32'h22222222);
        chk("op9_start", E_MDU_start, 1'b0);
        step();
        chk("op9_busy", E_MDU_busy, 1'b0);
        chk("op9_hi", E_HI, 32'h11111111);
        chk("op9_lo", E_LO, 32'h22222222);
        MDUOp = 4'd0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

E-stage multiply/divide unit of the five-stage MIPS pipeline. It sits beside the ALU and consumes the same forwarded E-stage operands as the ALU operand muxes (E_V1_f, E_V2_f). It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It exports start/busy so the D-stage stall unit can freeze mfhi/mflo/mthi/mtlo/md instructions while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- E_V1_f  in  32  forwarded rs operand
- E_V2_f  in  32  forwarded rt operand
- MDUOp  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7–15 treated as NOP
- MDUSel  in  1  read select: 1 = HI, 0 = LO
- E_MDU_start  out  1  combinational; 1 when MDUOp ∈ {1..4} and busy = 0
- E_MDU_busy  out  1  registered; operation in flight
- E_MDU_out  out  32  combinational; MDUSel ? HI : LO (current register value)
- E_HI  out  32  HI register
- E_LO  out  32  LO register

## Operation
- Registers: HI, LO, busy, cnt (≥4 bits), latched operands/op or precomputed 64-bit result.
- Reset values: HI = 0, LO = 0, busy = 0, cnt = 0, latched result = 0. E_MDU_start and E_MDU_out follow from these.
- Start edge (E_MDU_start = 1):
  - latch the result: MULT {HI,LO} = signed 64-bit product; MULTU = unsigned product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - cnt ← MULT_CYCLES or DIV_CYCLES; busy ← 1.
- Busy edges: cnt ← cnt−1. On the edge where cnt = 1: busy ← 0, HI/LO ← latched result.
- HI/LO never change while busy = 1.
- Divide by zero (E_V2_f = 0 on DIV/DIVU): runs full DIV_CYCLES; HI and LO retain their pre-op values.
- MTHI/MTLO: when busy = 0, HI (resp. LO) ← E_V1_f at the next edge. When busy = 1, ignored.
- MDUOp 1–4 while busy = 1: ignored; no restart, no latch. The stall unit must prevent this; the block is robust to it.
- Reset asserted mid-operation: the operation is discarded and all state returns to reset values at once. The next edge after reset deasserts behaves as idle.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.

## Timing
- Start sampled at edge T0. E_MDU_busy is high during cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO carry the new result and busy = 0 from cycle T0+N+1.
- Back-to-back: a new start is accepted at edge T0+N+1, the first cycle busy = 0. There are no idle bubbles.
- MTHI/MTLO latency: 1 edge. An mfhi in the following cycle reads the new value.
- E_MDU_out is purely combinational from HI/LO/MDUSel. There is no internal bypass of a same-cycle mthi into E_MDU_out.
- Stall contract (external): stall D-stage MD-class instructions when E_MDU_start | E_MDU_busy.

## Test plan
- Reset, then MULT 0xFFFFFFFE × 3 (signed): busy high for exactly 5 cycles. Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU of the same operands: HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV −7 / 2: busy high for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2: LO = 3, HI = 1.
- MTHI 0x12345678, then MTLO 0xCAFEBABE, then a DIV by 0: after 10 busy cycles, HI = 0x12345678 and LO = 0xCAFEBABE are unchanged.
- MULT 4×5 started, MTLO 0x1 and DIV presented at cycle 2 of busy: both ignored. Busy still falls after 5 cycles; LO = 20, HI = 0. A new MULT on the first non-busy cycle is accepted, with no gap.
- DIV started, reset pulsed asynchronously mid-cycle at busy cycle 4: busy, HI and LO go to 0 immediately without waiting for an edge. No late writeback occurs.
- MDUSel toggled while idle: E_MDU_out switches between HI and LO in the same cycle. MDUOp = 9 leaves all state unchanged and start = 0.
